sr_latch_driver: RTL and testbench

- Clocked initiator that drives a NAND-style SR latch through active-low set/reset strobes.
- Accepts set/reset commands on a valid/ready handshake and generates a glitch-free strobe of programmable width.
- Enforces a recovery gap after each strobe, then reads back the latch output through a 2-flop synchronizer and flags mismatches.
- Sits between control logic and any NAND SR latch (s_n/r_n low-active, both-high = hold); guarantees the invalid both-low input is never produced.

---
 rtl/sr_drv_pkg.sv | 14 +
 rtl/sync_2ff.sv | 27 ++
 rtl/sr_latch_driver.sv | 119 +++++++++++
 tb/tb_sr_latch_driver.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the SR latch strobe driver.
package sr_drv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2,
      CHECK = 2'd3
   } state_t;

   localparam logic CMD_SET   = 1'b1;
   localparam logic CMD_RESET = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous levels into the clk domain.
// Latency: two clk edges; no flow control.
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Drives a NAND SR latch with a PULSE_W-cycle low strobe, waits GAP_W cycles, then verifies readback.
// Handshake-to-done is PULSE_W+GAP_W+1 cycles; req_ready stays low while a command is in flight.
module sr_latch_driver
   import sr_drv_pkg::*;
#(
   parameter int PULSE_W = 3,
   parameter int GAP_W   = 2,
   parameter int CNT_W   = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic req_valid,
   input  logic req_set,
   output logic req_ready,
   output logic s_n,
   output logic r_n,
   input  logic q_fb,
   output logic busy,
   output logic done,
   output logic err,
   input  logic err_clr
);

   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cmd_q, cmd_d;
   logic             s_n_q, s_n_d;
   logic             r_n_q, r_n_d;
   logic             err_q, err_d;
   logic             err_set;
   logic             q_sync;

   sync_2ff #(.W(1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (q_fb),
      .q_o   (q_sync)
   );

   // Gated by rst_n so the requester sees no acceptance window during reset.
   assign req_ready = rst_n && (state_q == IDLE) && en;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == CHECK);
   assign s_n       = s_n_q;
   assign r_n       = r_n_q;
   assign err       = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      s_n_d   = s_n_q;
      r_n_d   = r_n_q;
      err_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               cmd_d   = req_set;
               cnt_d   = PULSE_LD;
               state_d = PULSE;
               s_n_d   = (req_set != CMD_SET);
               r_n_d   = (req_set != CMD_RESET);
            end
         end
         PULSE: begin
            if (cnt_q == '0) begin
               s_n_d   = 1'b1;
               r_n_d   = 1'b1;
               cnt_d   = GAP_LD;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               state_d = CHECK;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         CHECK: begin
            state_d = IDLE;
            err_set = (q_sync != cmd_q);
         end
         default: begin
            state_d = IDLE;
            s_n_d   = 1'b1;
            r_n_d   = 1'b1;
         end
      endcase
      // A fresh mismatch outranks a simultaneous clear.
      err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cmd_q   <= CMD_RESET;
         s_n_q   <= 1'b1;
         r_n_q   <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         s_n_q   <= s_n_d;
         r_n_q   <= r_n_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver with a NAND latch model on the strobe outputs.
module tb_sr_latch_driver;

   localparam int PULSE_W = 3;
   localparam int GAP_W   = 2;
   localparam int CNT_W   = 4;
   localparam int LAT     = PULSE_W + GAP_W + 1;
   localparam int PERIOD  = PULSE_W + GAP_W + 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic req_valid = 1'b0;
   logic req_set = 1'b0;
   logic req_ready, s_n, r_n, busy, done, err;
   logic q_fb;
   logic err_clr = 1'b0;

   sr_latch_driver #(.PULSE_W(PULSE_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req_valid (req_valid),
      .req_set   (req_set),
      .req_ready (req_ready),
      .s_n       (s_n),
      .r_n       (r_n),
      .q_fb      (q_fb),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_clr   (err_clr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // NAND SR latch: low s_n sets, low r_n resets, both high holds.
   logic q_lat = 1'b0;
   logic stuck = 1'b0;
   always @(s_n or r_n) begin
      if (!s_n && r_n) q_lat = 1'b1;
      else if (!r_n && s_n) q_lat = 1'b0;
   end
   assign q_fb = stuck ? 1'b0 : q_lat;

   typedef struct {
      logic cmd;
      logic exp_rb;
      int   hs;
   } rec_t;
   rec_t sb[$];

   int n_chk = 0;
   int n_fail = 0;
   logic mon_en = 1'b0;
   logic err_exp = 1'b0;
   int s_cnt = 0, r_cnt = 0, hi_run = 0;
   logic seen_strobe = 1'b0;
   logic prev_low = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: per-cycle invariants, sticky-error model, and scoreboard pop on done.
   always @(negedge clk) begin
      if (mon_en) begin
         logic low;
         logic mism;
         rec_t rec;
         mism = 1'b0;
         low = !s_n || !r_n;
         check("both_low", {31'd0, (!s_n && !r_n)}, 0);
         if (low && !prev_low && seen_strobe)
            check("gap_between_strobes", {31'd0, (hi_run >= GAP_W + 2)}, 1);
         if (low) begin
            seen_strobe = 1'b1;
            hi_run = 0;
         end else begin
            hi_run++;
         end
         prev_low = low;
         if (!s_n) s_cnt++;
         if (!r_n) r_cnt++;
         check("err", {31'd0, err}, {31'd0, err_exp});
         if (done) begin
            if (sb.size() == 0) begin
               check("done_without_cmd", 1, 0);
            end else begin
               rec = sb.pop_front();
               check("done_latency", cyc - rec.hs, LAT);
               check("set_strobe_len", s_cnt, rec.cmd ? PULSE_W : 0);
               check("rst_strobe_len", r_cnt, rec.cmd ? 0 : PULSE_W);
               mism = (rec.exp_rb != rec.cmd);
            end
            s_cnt = 0;
            r_cnt = 0;
         end
         err_exp = (done && mism) ? 1'b1 : (err_clr ? 1'b0 : err_exp);
      end
   end

   // Hold req_valid until accepted; push the expected outcome at the handshake.
   task automatic issue(input logic cmd, output int hs);
      rec_t rec;
      req_set = cmd;
      req_valid = 1'b1;
      hs = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (req_ready) begin
            hs = cyc;
            rec.cmd = cmd;
            rec.exp_rb = stuck ? 1'b0 : cmd;
            rec.hs = cyc;
            sb.push_back(rec);
            break;
         end
      end
      if (hs < 0) check("handshake_timeout", 1, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int ok;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy) begin
            ok = 1;
            break;
         end
      end
      if (ok == 0) check("idle_timeout", 1, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n, input logic rand_clr);
      for (int i = 0; i < n; i++) begin
         err_clr = rand_clr && ($urandom_range(0, 3) == 0);
         @(posedge clk);
         #1;
      end
      err_clr = 1'b0;
   endtask

   initial begin
      int hs, hs2;
      // Reset state, with en high so req_ready gating by reset is visible.
      en = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_s_n", {31'd0, s_n}, 1);
      check("rst_r_n", {31'd0, r_n}, 1);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_err", {31'd0, err}, 0);
      check("rst_req_ready", {31'd0, req_ready}, 0);
      rst_n = 1'b1;
      #1;
      mon_en = 1'b1;
      check("post_rst_req_ready", {31'd0, req_ready}, 1);
      @(posedge clk);
      #1;

      // Set, then reset, from a known latch state.
      issue(1'b1, hs);
      req_valid = 1'b0;
      wait_idle();
      check("latch_after_set", {31'd0, q_lat}, 1);
      issue(1'b0, hs);
      req_valid = 1'b0;
      wait_idle();
      check("latch_after_reset", {31'd0, q_lat}, 0);

      // Back-to-back with req_valid held: acceptance only once IDLE returns.
      issue(1'b1, hs);
      issue(1'b0, hs2);
      req_valid = 1'b0;
      check("b2b_period", hs2 - hs, PERIOD);
      wait_idle();

      // Dropping en mid-strobe must not truncate the command.
      issue(1'b1, hs);
      req_valid = 1'b0;
      en = 1'b0;
      wait_idle();
      en = 1'b1;

      // en low in IDLE blocks acceptance and produces no strobe.
      en = 1'b0;
      req_valid = 1'b1;
      req_set = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("en_low_ready", {31'd0, req_ready}, 0);
         check("en_low_no_strobe", {30'd0, s_n, r_n}, 3);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      en = 1'b1;

      // Readback mismatch with the latch stuck low; clear colliding with a new mismatch.
      stuck = 1'b1;
      idle_cycles(3, 1'b0);
      issue(1'b1, hs);
      req_valid = 1'b0;
      wait_idle();
      check("err_after_mismatch", {31'd0, err}, 1);
      issue(1'b1, hs);
      req_valid = 1'b0;
      while (cyc < hs + LAT) begin
         @(posedge clk);
         #1;
      end
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      check("err_set_wins", {31'd0, err}, 1);
      stuck = 1'b0;
      idle_cycles(3, 1'b0);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      check("err_cleared", {31'd0, err}, 0);

      // Randomized commands, stuck-latch faults, gaps and clears.
      for (int n = 0; n < 20; n++) begin
         stuck = ($urandom_range(0, 3) == 0);
         idle_cycles($urandom_range(1, 5), 1'b1);
         issue(1'($urandom_range(0, 1)), hs);
         req_valid = 1'b0;
         if ($urandom_range(0, 1) == 1) en = 1'b0;
         wait_idle();
         en = 1'b1;
      end
      stuck = 1'b0;

      // Asynchronous reset in the middle of a set strobe.
      issue(1'b1, hs);
      req_valid = 1'b0;
      @(negedge clk);
      check("mid_pulse_s_n_low", {31'd0, s_n}, 0);
      mon_en = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_s_n", {31'd0, s_n}, 1);
      check("async_rst_r_n", {31'd0, r_n}, 1);
      check("async_rst_busy", {31'd0, busy}, 0);
      check("async_rst_err", {31'd0, err}, 0);
      check("async_rst_ready", {31'd0, req_ready}, 0);
      sb.delete();
      s_cnt = 0;
      r_cnt = 0;
      hi_run = 0;
      seen_strobe = 1'b0;
      prev_low = 1'b0;
      err_exp = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      mon_en = 1'b1;
      check("release_ready", {31'd0, req_ready}, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("no_done_after_rst", {30'd0, done, busy}, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
